// File: rtl/conv1d_pkg.sv
// ----------------------------------------------------------------------------
// conv1d_pkg
//   Shared definitions for the conv1d core datapath.
//   - MUX_MODE_SEL / MUX_MODE_RR : encodings of the stream mux rr_en input
//   - CONV1D_MUX_N_CH            : channel count of the default mux config
//   - chan_idx_t                 : channel index type for the default config
//   - rr_wrap()                  : single-step modulo used by the arbiter scan
// ----------------------------------------------------------------------------
package conv1d_pkg;

    localparam logic MUX_MODE_SEL = 1'b0;
    localparam logic MUX_MODE_RR  = 1'b1;

    localparam int CONV1D_MUX_N_CH = 4;

    typedef logic [$clog2(CONV1D_MUX_N_CH)-1:0] chan_idx_t;

    // Wraps idx into [0, n) assuming idx < 2*n, which holds for ptr + offset
    // as long as ptr is itself a valid channel index.
    function automatic int rr_wrap(input int idx, input int n);
        return (idx >= n) ? idx - n : idx;
    endfunction

endpackage

// File: rtl/rr_arbiter_n.sv
// ----------------------------------------------------------------------------
// rr_arbiter_n
//   Combinational round-robin arbiter. Grants the first requesting channel
//   found scanning upward from ptr+1, wrapping at N_CH-1, with ptr itself
//   checked last. The pointer register lives in the parent.
//
//   Ports
//     req      in  [N_CH-1:0]  request vector
//     ptr      in  [SEL_W-1:0] last granted channel
//     en       in              arbitration enable; no grant when low
//     gnt_oh   out [N_CH-1:0]  one-hot grant (zero when no grant)
//     gnt_idx  out [SEL_W-1:0] granted channel index
//     gnt_vld  out             a grant was issued
// ----------------------------------------------------------------------------
module rr_arbiter_n
    import conv1d_pkg::*;
#(
    parameter  int N_CH  = 4,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    input  logic             en,
    output logic [N_CH-1:0]  gnt_oh,
    output logic [SEL_W-1:0] gnt_idx,
    output logic             gnt_vld
);

    int               c;
    logic [SEL_W-1:0] ci;

    // Scan offsets from farthest to nearest; the last hit written is the
    // nearest requester after ptr, which is the round-robin winner.
    always_comb begin
        gnt_oh  = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        c       = 0;
        ci      = '0;
        if (en) begin
            for (int k = N_CH; k >= 1; k--) begin
                c  = rr_wrap(int'(ptr) + k, N_CH);
                ci = SEL_W'(c);
                if (req[ci]) begin
                    gnt_oh     = '0;
                    gnt_oh[ci] = 1'b1;
                    gnt_idx    = ci;
                    gnt_vld    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mux_n_stream.sv
// ----------------------------------------------------------------------------
// mux_n_stream
//   N-channel valid/ready stream multiplexer with a single registered output
//   stage. The source channel is either an explicit index (select mode) or
//   a fair round-robin choice, chosen per cycle by rr_en. The output stage
//   refills on the same edge it drains, giving one word per cycle.
//
//   Ports
//     clk        in                 clock, rising edge
//     rst_n      in                 asynchronous active-low reset
//     rr_en      in                 0 = select mode, 1 = round-robin mode
//     sel        in  [SEL_W-1:0]    channel index in select mode
//     in_valid   in  [N_CH-1:0]     per-channel valid
//     in_data    in  [N_CH*N_BIT-1:0] packed data, channel k at [k*N_BIT +: N_BIT]
//     in_ready   out [N_CH-1:0]     per-channel ready, one-hot or zero
//     out_valid  out                output register holds a word
//     out_data   out [N_BIT-1:0]    registered data
//     out_ch     out [SEL_W-1:0]    source channel of out_data
//     out_ready  in                 downstream accepts the word
// ----------------------------------------------------------------------------
module mux_n_stream
    import conv1d_pkg::*;
#(
    parameter  int N_BIT = 8,
    parameter  int N_CH  = 4,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rr_en,
    input  logic [SEL_W-1:0]      sel,
    input  logic [N_CH-1:0]       in_valid,
    input  logic [N_CH*N_BIT-1:0] in_data,
    output logic [N_CH-1:0]       in_ready,
    output logic                  out_valid,
    output logic [N_BIT-1:0]      out_data,
    output logic [SEL_W-1:0]      out_ch,
    input  logic                  out_ready
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic             out_valid_q, out_valid_d;
    logic [N_BIT-1:0] out_data_q,  out_data_d;
    logic [SEL_W-1:0] out_ch_q,    out_ch_d;
    logic [SEL_W-1:0] ptr_q,       ptr_d;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic [N_CH-1:0][N_BIT-1:0] chan_data;
    logic                       rr_mode;
    logic                       load_en;
    logic                       sel_in_range;
    logic [N_CH-1:0]            arb_oh;
    logic [SEL_W-1:0]           arb_idx;
    logic                       arb_vld;
    logic [N_CH-1:0]            g_oh;
    logic [SEL_W-1:0]           g_idx;
    logic                       g_vld;
    logic                       xfer;

    // Packed-array view of the flat input bus; same bit layout.
    assign chan_data = in_data;
    assign rr_mode   = (rr_en == MUX_MODE_RR);

    rr_arbiter_n #(
        .N_CH (N_CH)
    ) u_arb (
        .req     (in_valid),
        .ptr     (ptr_q),
        .en      (rr_mode),
        .gnt_oh  (arb_oh),
        .gnt_idx (arb_idx),
        .gnt_vld (arb_vld)
    );

    // ------------------------------------------------------------------
    // Grant selection and handshake
    // ------------------------------------------------------------------
    always_comb begin
        load_en      = !out_valid_q || out_ready;
        // Only reachable when N_CH is not a power of two.
        sel_in_range = (int'(sel) < N_CH);

        if (rr_mode) begin
            g_vld = arb_vld;
            g_idx = arb_idx;
            g_oh  = arb_oh;
        end else begin
            g_vld = sel_in_range && in_valid[sel];
            g_idx = sel;
            g_oh  = g_vld ? (N_CH'(1) << sel) : '0;
        end

        // A granted channel is valid by construction, so ready alone
        // completes the transfer condition.
        in_ready = load_en ? g_oh : '0;
        xfer     = load_en && g_vld;
    end

    // ------------------------------------------------------------------
    // Next-state
    // ------------------------------------------------------------------
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        ptr_d       = ptr_q;

        // Draining with nothing to refill empties the stage; data and
        // channel keep their last values.
        if (load_en) begin
            out_valid_d = g_vld;
        end

        if (xfer) begin
            out_data_d = chan_data[g_idx];
            out_ch_d   = g_idx;
            // Select-mode traffic must not disturb round-robin fairness.
            if (rr_mode) begin
                ptr_d = g_idx;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            // Parked on the last channel so channel 0 wins the first scan.
            ptr_q       <= SEL_W'(N_CH - 1);
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

    // ------------------------------------------------------------------
    // Protocol properties
    // ------------------------------------------------------------------
    a_ready_onehot0: assert property (
        @(posedge clk) disable iff (!rst_n) $onehot0(in_ready)
    );

    a_hold_under_bp: assert property (
        @(posedge clk) disable iff (!rst_n)
        (out_valid_q && !out_ready) |=>
            (out_valid_q && $stable(out_data_q) && $stable(out_ch_q))
    );

endmodule

// File: tb/tb_mux_n_stream.sv
module tb_mux_n_stream;

    localparam int N_BIT = 8;
    localparam int N_CH  = 4;

    logic        clk;
    logic        rst_n;
    logic        rr_en;
    logic [1:0]  sel;
    logic [3:0]  in_valid;
    logic [31:0] in_data;
    logic [3:0]  in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_ch;
    logic        out_ready;

    int n_vec;
    int n_err;

    mux_n_stream #(.N_BIT(N_BIT), .N_CH(N_CH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rr_en     (rr_en),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_ready (out_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: grant from the written rules, plus an ordered list
    // of accepted words that must each leave the output exactly once.
    // ------------------------------------------------------------------
    function automatic int model_grant(input logic rr, input logic [1:0] s,
                                       input logic [3:0] v, input int p);
        if (!rr) return (int'(s) < N_CH && v[s]) ? int'(s) : -1;
        for (int k = 1; k <= N_CH; k++) begin
            int c;
            c = (p + k) % N_CH;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    int         m_ptr;
    logic       m_vld;
    logic [7:0] m_data;
    int         m_ch;
    int         g_now;
    logic       m_load;
    logic [9:0] sb[$];

    always_comb begin
        g_now  = model_grant(rr_en, sel, in_valid, m_ptr);
        m_load = !m_vld || out_ready;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ptr  <= N_CH - 1;
            m_vld  <= 1'b0;
            m_data <= 8'h00;
            m_ch   <= 0;
            sb.delete();
        end else if (m_load) begin
            if (g_now >= 0) begin
                m_vld  <= 1'b1;
                m_data <= in_data[g_now*8 +: 8];
                m_ch   <= g_now;
                sb.push_back({2'(g_now), in_data[g_now*8 +: 8]});
                if (rr_en) m_ptr <= g_now;
            end else begin
                m_vld <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready", 32'(in_ready),
                (m_load && g_now >= 0) ? (32'd1 << g_now) : 32'd0);
            chk("out_valid", 32'(out_valid), 32'(m_vld));
            chk("out_data", 32'(out_data), 32'(m_data));
            chk("out_ch", 32'(out_ch), 32'(m_ch));
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 32'd1, 32'd0);
                end else begin
                    chk("sb_order", {22'd0, out_ch, out_data}, {22'd0, sb.pop_front()});
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus with hand-computed expectations
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rr, input logic [1:0] s, input logic [3:0] v,
                         input logic [31:0] d, input logic rdy);
        rr_en     = rr;
        sel       = s;
        in_valid  = v;
        in_data   = d;
        out_ready = rdy;
        #1;
    endtask

    int rr_exp[6] = '{0, 1, 2, 3, 0, 1};
    int alt_exp[3] = '{1, 3, 1};

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        rr_en = 1'b0; sel = 2'd0; in_valid = 4'b0; in_data = 32'h0; out_ready = 1'b0;

        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_ch", 32'(out_ch), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;

        // Select mode, channel 2.
        tick();
        drive(1'b0, 2'd2, 4'b0100, 32'h00A5_0000, 1'b1);
        chk("t1_in_ready", 32'(in_ready), 32'b0100);
        tick();
        chk("t1_out_valid", 32'(out_valid), 32'd1);
        chk("t1_out_data", 32'(out_data), 32'hA5);
        chk("t1_out_ch", 32'(out_ch), 32'd2);

        // Round-robin, all channels valid, no bubbles.
        drive(1'b1, 2'd0, 4'b1111, 32'h4433_2211, 1'b1);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("t2_rr_ch", 32'(out_ch), 32'(rr_exp[i]));
            chk("t2_rr_valid", 32'(out_valid), 32'd1);
        end

        // Park ptr on 3, then alternate between channels 1 and 3.
        drive(1'b1, 2'd0, 4'b1000, 32'h4433_2211, 1'b1);
        tick();
        chk("t3_park_ch", 32'(out_ch), 32'd3);
        drive(1'b1, 2'd0, 4'b1010, 32'h4433_2211, 1'b1);
        chk("t3_in_ready", 32'(in_ready), 32'b0010);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t3_alt_ch", 32'(out_ch), 32'(alt_exp[i]));
        end
        drive(1'b1, 2'd0, 4'b0001, 32'h4433_2211, 1'b1);
        tick();
        chk("t3_ch0", 32'(out_ch), 32'd0);
        chk("t3_ch0_data", 32'(out_data), 32'h11);

        // Backpressure with 0x3C held.
        drive(1'b0, 2'd0, 4'b0001, 32'h0000_003C, 1'b1);
        tick();
        chk("t4_load", 32'(out_data), 32'h3C);
        drive(1'b0, 2'd0, 4'b1111, 32'h1122_3344, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("t4_bp_ready", 32'(in_ready), 32'd0);
            tick();
            chk("t4_bp_data", 32'(out_data), 32'h3C);
            chk("t4_bp_valid", 32'(out_valid), 32'd1);
        end
        drive(1'b0, 2'd1, 4'b0010, 32'h0000_7700, 1'b1);
        chk("t4_release_ready", 32'(in_ready), 32'b0010);
        tick();
        chk("t4_new_data", 32'(out_data), 32'h77);
        chk("t4_new_ch", 32'(out_ch), 32'd1);

        // Select mode pointing at an idle channel: drain then empty.
        drive(1'b0, 2'd1, 4'b1101, 32'hDEAD_BEEF, 1'b1);
        chk("t5_no_ready", 32'(in_ready), 32'd0);
        tick();
        chk("t5_drained", 32'(out_valid), 32'd0);
        tick();
        chk("t5_still_empty", 32'(out_valid), 32'd0);
        chk("t5_data_hold", 32'(out_data), 32'h77);

        // Reset mid-stream with ptr=2.
        drive(1'b1, 2'd0, 4'b0100, 32'h0099_0000, 1'b1);
        tick();
        chk("t6_pre_valid", 32'(out_valid), 32'd1);
        chk("t6_pre_ch", 32'(out_ch), 32'd2);
        drive(1'b1, 2'd0, 4'b0000, 32'h0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_valid", 32'(out_valid), 32'd0);
        chk("t6_async_data", 32'(out_data), 32'd0);
        chk("t6_async_ch", 32'(out_ch), 32'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        drive(1'b1, 2'd0, 4'b1111, 32'h4433_2211, 1'b1);
        tick();
        chk("t6_first_ch", 32'(out_ch), 32'd0);
        chk("t6_first_data", 32'(out_data), 32'h11);

        // Mixed traffic, checked by the per-cycle model.
        for (int i = 0; i < 60; i++) begin
            drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  4'($urandom_range(0, 15)), $urandom, 1'($urandom_range(0, 3) != 0));
            tick();
        end
        drive(1'b0, 2'd0, 4'b0000, 32'h0, 1'b1);
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
